// File: rtl/uart_fifo_core_if.sv
// Host-side byte interface of uart_fifo_core: TX push, RX show-ahead pop, status flags.
interface uart_fifo_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_wr;
  logic                 tx_full;
  logic                 tx_busy;
  logic                 tx_done;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_rd;
  logic                 rx_empty;
  logic                 rx_overrun;
  logic                 err_clr;

  modport master (
    output tx_data, tx_wr, rx_rd, err_clr,
    input  tx_full, tx_busy, tx_done, rx_data, rx_frame_err, rx_parity_err,
           rx_empty, rx_overrun
  );

  modport slave (
    input  tx_data, tx_wr, rx_rd, err_clr,
    output tx_full, tx_busy, tx_done, rx_data, rx_frame_err, rx_parity_err,
           rx_empty, rx_overrun
  );
endinterface

// File: rtl/uart_fifo_core.sv
// Single-clock UART: baud tick enable, TX/RX FIFOs, 16x-oversampled receiver, loopback.
// state    | meaning
// S_IDLE   | line idle (TX: wait for FIFO data, RX: wait for low line)
// S_START  | start bit (RX: half-bit glitch check)
// S_DATA   | data bits, LSB first
// S_PARITY | optional parity bit
// S_STOP   | stop bit(s)
module uart_fifo_core #(
  parameter int CLOCK_FREQ = 38400000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  uart_fifo_core_if.slave    bus,
  input  logic               loopback,
  input  logic               rx_pin,
  output logic               tx_pin
);
  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int EW  = DATA_BITS + 2;
  localparam logic ODD = 1'(PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DW-1:0] baud_cnt;
  logic          tick;

  assign tick = (baud_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else baud_cnt <= baud_cnt + 1'b1;
  end

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wp, tx_rp;
  logic                 tx_empty, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty    = (tx_wp == tx_rp);
  assign bus.tx_full = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign tx_push     = bus.tx_wr && !bus.tx_full;
  assign tx_head     = tx_mem[tx_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= bus.tx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  // TX serializer
  state_t               tx_st;
  logic [OW-1:0]        tx_os;
  logic [3:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par, tx_line, tx_busy_q, tx_done_q;
  logic                 tx_bit_end, tx_last;

  assign tx_bit_end = tick && (tx_st != S_IDLE) && (tx_os == OW'(OVERSAMPLE - 1));
  assign tx_last    = tx_bit_end && (tx_st == S_STOP) && (tx_bit == 4'(STOP_BITS - 1));
  // A pop at the end of the last stop bit gives back-to-back frames with no idle gap.
  assign tx_pop     = tick && !tx_empty && ((tx_st == S_IDLE) || tx_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_st     <= S_IDLE;
      tx_os     <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
      tx_par    <= 1'b0;
      tx_line   <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= tx_last;
      if (tx_pop) begin
        tx_st     <= S_START;
        tx_os     <= '0;
        tx_bit    <= '0;
        tx_sh     <= tx_head;
        tx_par    <= (^tx_head) ^ ODD;
        tx_line   <= 1'b0;
        tx_busy_q <= 1'b1;
      end else if (tx_bit_end) begin
        tx_os <= '0;
        case (tx_st)
          S_START: begin
            tx_st   <= S_DATA;
            tx_line <= tx_sh[0];
            tx_bit  <= '0;
          end
          S_DATA: begin
            if (tx_bit == 4'(DATA_BITS - 1)) begin
              tx_bit <= '0;
              if (PARITY != 0) begin
                tx_st   <= S_PARITY;
                tx_line <= tx_par;
              end else begin
                tx_st   <= S_STOP;
                tx_line <= 1'b1;
              end
            end else begin
              tx_bit  <= tx_bit + 1'b1;
              tx_sh   <= tx_sh >> 1;
              tx_line <= tx_sh[1];
            end
          end
          S_PARITY: begin
            tx_st   <= S_STOP;
            tx_line <= 1'b1;
          end
          S_STOP: begin
            if (tx_last) begin
              tx_st     <= S_IDLE;
              tx_busy_q <= 1'b0;
            end else begin
              tx_bit <= tx_bit + 1'b1;
            end
          end
          default: tx_st <= S_IDLE;
        endcase
      end else if (tick && (tx_st != S_IDLE)) begin
        tx_os <= tx_os + 1'b1;
      end
    end
  end

  assign tx_pin      = loopback ? 1'b1 : tx_line;
  assign bus.tx_busy = tx_busy_q;
  assign bus.tx_done = tx_done_q;

  // RX synchroniser and deserializer
  logic [1:0]           rx_sync;
  logic                 rx_s;
  state_t               rx_st;
  logic [OW-1:0]        rx_os;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_perr, rx_push;
  logic [EW-1:0]        rx_wdata;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_sync <= 2'b11;
    else rx_sync <= {rx_sync[0], loopback ? tx_line : rx_pin};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_st    <= S_IDLE;
      rx_os    <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_perr  <= 1'b0;
      rx_push  <= 1'b0;
      rx_wdata <= '0;
    end else begin
      rx_push <= 1'b0;
      if (tick) begin
        case (rx_st)
          S_IDLE: begin
            if (!rx_s) begin
              rx_st <= S_START;
              rx_os <= '0;
            end
          end
          S_START: begin
            if (rx_os == OW'(OVERSAMPLE / 2 - 1)) begin
              rx_os   <= '0;
              rx_bit  <= '0;
              rx_perr <= 1'b0;
              rx_st   <= rx_s ? S_IDLE : S_DATA;
            end else begin
              rx_os <= rx_os + 1'b1;
            end
          end
          default: begin
            if (rx_os != OW'(OVERSAMPLE - 1)) begin
              rx_os <= rx_os + 1'b1;
            end else begin
              rx_os <= '0;
              case (rx_st)
                S_DATA: begin
                  rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
                  if (rx_bit == 4'(DATA_BITS - 1)) rx_st <= (PARITY != 0) ? S_PARITY : S_STOP;
                  else rx_bit <= rx_bit + 1'b1;
                end
                S_PARITY: begin
                  rx_perr <= rx_s != ((^rx_sh) ^ ODD);
                  rx_st   <= S_STOP;
                end
                default: begin
                  rx_push  <= 1'b1;
                  rx_wdata <= {rx_sh, !rx_s, rx_perr};
                  rx_st    <= S_IDLE;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

  // RX FIFO: entry = {data, frame_err, parity_err}
  logic [EW-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]   rx_wp, rx_rp;
  logic          rx_full, rx_empty, rx_pop, rx_wr, rx_ovr_q;
  logic [EW-1:0] rx_head;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign rx_pop   = bus.rx_rd && !rx_empty;
  assign rx_wr    = rx_push && (!rx_full || rx_pop);
  assign rx_head  = rx_mem[rx_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wp[AW-1:0]] <= rx_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_ovr_q <= 1'b0;
    end else begin
      if (rx_wr)  rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      if (rx_push && rx_full && !rx_pop) rx_ovr_q <= 1'b1;
      else if (bus.err_clr) rx_ovr_q <= 1'b0;
    end
  end

  assign bus.rx_empty      = rx_empty;
  assign bus.rx_overrun    = rx_ovr_q;
  assign bus.rx_data       = rx_empty ? '0 : rx_head[EW-1:2];
  assign bus.rx_frame_err  = !rx_empty && rx_head[1];
  assign bus.rx_parity_err = !rx_empty && rx_head[0];
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench: 8N1 (a), 8E2 (b) and 8O1 (c) instances, 160 clk per bit.
module tb_uart_fifo_core;
  localparam int BIT = 160;

  logic clk = 1'b0;
  logic reset;
  logic lb_a, lb_b, lb_c;
  logic rx_a, rx_b, rx_c;
  logic tx_a, tx_b, tx_c;

  always #5 clk = ~clk;

  uart_fifo_core_if #(.DATA_BITS(8)) bus_a ();
  uart_fifo_core_if #(.DATA_BITS(8)) bus_b ();
  uart_fifo_core_if #(.DATA_BITS(8)) bus_c ();

  uart_fifo_core #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a), .loopback(lb_a), .rx_pin(rx_a), .tx_pin(tx_a));
  uart_fifo_core #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b), .loopback(lb_b), .rx_pin(rx_b), .tx_pin(tx_b));
  uart_fifo_core #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_c (.clk(clk), .reset(reset), .bus(bus_c), .loopback(lb_c), .rx_pin(rx_c), .tx_pin(tx_c));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // odd-parity 8-bit frame: {stop, parity, data, start}
  function automatic logic [10:0] frame_o(input logic [7:0] d, input logic bad_par, input logic stop);
    return {stop, ~(^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send_c(input logic [10:0] f);
    for (int i = 0; i < 11; i++) begin
      rx_c = f[i];
      repeat (BIT) @(negedge clk);
    end
    rx_c = 1'b1;
  endtask

  task automatic pop_c();
    bus_c.rx_rd = 1'b1;
    @(negedge clk);
    bus_c.rx_rd = 1'b0;
  endtask

  int to, t, done_t, done_cnt, f, r, k;
  logic lb_bad, done_bad, busy_gap, line_bad;
  logic [11:0] bits_b, exp_b;
  logic [9:0] fb [4];
  logic [7:0] vals [5];

  initial begin
    reset = 1'b0;
    lb_a = 1'b0; lb_b = 1'b0; lb_c = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    bus_a.tx_data = '0; bus_a.tx_wr = 1'b0; bus_a.rx_rd = 1'b0; bus_a.err_clr = 1'b0;
    bus_b.tx_data = '0; bus_b.tx_wr = 1'b0; bus_b.rx_rd = 1'b0; bus_b.err_clr = 1'b0;
    bus_c.tx_data = '0; bus_c.tx_wr = 1'b0; bus_c.rx_rd = 1'b0; bus_c.err_clr = 1'b0;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
    repeat (3) @(negedge clk);

    chk("rst_tx_pin", tx_a, 1);
    chk("rst_tx_pin_c", tx_c, 1);
    chk("rst_busy", bus_a.tx_busy, 0);
    chk("rst_done", bus_a.tx_done, 0);
    chk("rst_full", bus_a.tx_full, 0);
    chk("rst_empty", bus_a.rx_empty, 1);
    chk("rst_rx_data", bus_a.rx_data, 0);
    chk("rst_errs", {bus_a.rx_frame_err, bus_a.rx_parity_err, bus_a.rx_overrun}, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 loopback
    lb_a = 1'b1;
    bus_a.tx_data = 8'hA5; bus_a.tx_wr = 1'b1;
    @(negedge clk);
    bus_a.tx_wr = 1'b0;
    to = 0;
    while (!bus_a.tx_busy && to < 100) begin @(negedge clk); to++; end
    chk("t1_busy_timeout", to >= 100, 0);
    t = 0; lb_bad = 1'b0;
    while (!bus_a.tx_done && t < 2000) begin
      if (tx_a !== 1'b1) lb_bad = 1'b1;
      @(negedge clk); t++;
    end
    chk("t1_done_latency", t, 1600);
    chk("t1_lb_tx_pin_high", lb_bad, 0);
    chk("t1_busy_end", bus_a.tx_busy, 0);
    to = 0;
    while (bus_a.rx_empty && to < 200) begin @(negedge clk); to++; end
    chk("t1_rx_data", bus_a.rx_data, 8'hA5);
    chk("t1_rx_errs", {bus_a.rx_frame_err, bus_a.rx_parity_err}, 0);
    bus_a.rx_rd = 1'b1;
    @(negedge clk);
    bus_a.rx_rd = 1'b0;
    chk("t1_rx_empty_after_pop", bus_a.rx_empty, 1);
    lb_a = 1'b0;

    // 8E2 waveform of 0x3C
    bus_b.tx_data = 8'h3C; bus_b.tx_wr = 1'b1;
    @(negedge clk);
    bus_b.tx_wr = 1'b0;
    to = 0;
    while (tx_b && to < 100) begin @(negedge clk); to++; end
    chk("t2_start_timeout", to >= 100, 0);
    t = 0; done_t = -1; bits_b = '0;
    while (t <= 2000) begin
      if (t >= 80 && ((t - 80) % BIT) == 0 && ((t - 80) / BIT) < 12) bits_b[(t - 80) / BIT] = tx_b;
      if (bus_b.tx_done && done_t < 0) done_t = t;
      @(negedge clk); t++;
    end
    exp_b = 12'hC78;
    for (int i = 0; i < 12; i++) chk($sformatf("t2_bit%0d", i), bits_b[i], exp_b[i]);
    chk("t2_frame_len", done_t, 1920);

    // RX injection: stop error, then parity error
    send_c(frame_o(8'h55, 1'b0, 1'b0));
    repeat (2 * BIT) @(negedge clk);
    send_c(frame_o(8'h12, 1'b1, 1'b1));
    repeat (2 * BIT) @(negedge clk);
    chk("t3_not_empty", bus_c.rx_empty, 0);
    chk("t3_e0_data", bus_c.rx_data, 8'h55);
    chk("t3_e0_errs", {bus_c.rx_frame_err, bus_c.rx_parity_err}, 2'b10);
    pop_c();
    chk("t3_e1_data", bus_c.rx_data, 8'h12);
    chk("t3_e1_errs", {bus_c.rx_frame_err, bus_c.rx_parity_err}, 2'b01);
    pop_c();
    chk("t3_empty", bus_c.rx_empty, 1);

    // RX overrun
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) chk("t4_ovr_after4", bus_c.rx_overrun, 0);
      send_c(frame_o(8'(i), 1'b0, 1'b1));
      repeat (BIT) @(negedge clk);
    end
    chk("t4_overrun", bus_c.rx_overrun, 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t4_e%0d", i), {bus_c.rx_empty, bus_c.rx_frame_err, bus_c.rx_parity_err, bus_c.rx_data},
          {3'b000, 8'(i)});
      pop_c();
    end
    chk("t4_empty", bus_c.rx_empty, 1);
    chk("t4_ovr_sticky", bus_c.rx_overrun, 1);
    bus_c.err_clr = 1'b1;
    @(negedge clk);
    bus_c.err_clr = 1'b0;
    chk("t4_ovr_clr", bus_c.rx_overrun, 0);

    // TX back-to-back; align writes just after a tick via tx_done
    bus_a.tx_data = 8'hFF; bus_a.tx_wr = 1'b1;
    @(negedge clk);
    bus_a.tx_wr = 1'b0;
    to = 0;
    while (!bus_a.tx_done && to < 2000) begin @(negedge clk); to++; end
    chk("t5_prep_timeout", to >= 2000, 0);
    for (int i = 0; i < 5; i++) begin
      bus_a.tx_data = vals[i]; bus_a.tx_wr = 1'b1;
      @(negedge clk);
      if (i == 2) chk("t5_full_after3", bus_a.tx_full, 0);
      if (i == 3) chk("t5_full_after4", bus_a.tx_full, 1);
    end
    bus_a.tx_wr = 1'b0;
    to = 0;
    while (tx_a && to < 100) begin @(negedge clk); to++; end
    chk("t5_start_timeout", to >= 100, 0);
    t = 0; done_cnt = 0; done_bad = 1'b0; busy_gap = 1'b0;
    for (int i = 0; i < 4; i++) fb[i] = '0;
    while (t <= 4 * 1600 + 500) begin
      f = t / 1600; r = t % 1600;
      if (f < 4 && r >= 80 && ((r - 80) % BIT) == 0) begin
        k = (r - 80) / BIT;
        fb[f][k] = tx_a;
      end
      if (bus_a.tx_done) begin
        done_cnt++;
        if (r != 0) done_bad = 1'b1;
      end
      if (t < 6400 && !bus_a.tx_busy) busy_gap = 1'b1;
      @(negedge clk); t++;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("t5_frame%0d", i), fb[i], {1'b1, vals[i], 1'b0});
    chk("t5_done_cnt", done_cnt, 4);
    chk("t5_done_timing", done_bad, 0);
    chk("t5_busy_gap", busy_gap, 0);
    chk("t5_idle_after", bus_a.tx_busy, 0);

    // glitch on rx_pin
    rx_c = 1'b0;
    repeat (40) @(negedge clk);
    rx_c = 1'b1;
    repeat (2000) @(negedge clk);
    chk("t6_glitch_no_push", bus_c.rx_empty, 1);

    // reset mid-frame
    bus_b.tx_data = 8'h00; bus_b.tx_wr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_b.tx_wr = 1'b0;
    to = 0;
    while (tx_b && to < 100) begin @(negedge clk); to++; end
    chk("t6_start_timeout", to >= 100, 0);
    repeat (300) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_tx_pin", tx_b, 1);
    chk("t6_rst_busy", bus_b.tx_busy, 0);
    chk("t6_rst_rx_empty", bus_b.rx_empty, 1);
    reset = 1'b1;
    line_bad = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (!tx_b || bus_b.tx_busy) line_bad = 1'b1;
    end
    chk("t6_tx_fifo_flushed", line_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
